// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic {
        IDLE,
        FULL
    } arb_state_t;

    // Next requester index in rotation; the 2-bit width gives the 3 -> 0 wrap.
    function automatic req_idx_t idx_inc(input req_idx_t i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// Plain 4:1 datapath mux, the shared resource being arbitrated.
// Latency: combinational.
// Backpressure: none, pure select.
// Ports: in0..in3 data words, sel picks one, out is the selected word.
module mux_4x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/mux_4x1_rr_arbiter_rr_pick4.sv
// Rotating first-one finder: first set req bit searching ptr, ptr+1, ptr+2, ptr+3.
// Latency: combinational.
// Backpressure: none, pure selection.
// Ports: req request vector, ptr search start, gidx winning index, any = some req set.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output req_idx_t           gidx,
    output logic               any
);

    // Walk the rotated order from the far end back to ptr so the closest
    // set bit to ptr is the last assignment and therefore wins.
    always_comb begin
        gidx = ptr;
        any  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ptr + req_idx_t'(k)]) begin
                gidx = ptr + req_idx_t'(k);
            end
        end
    end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one mux_4x1 between four valid/ready requesters.
// Latency: one cycle from request handshake to out_valid; 1 word/cycle when out_ready=1.
// Backpressure: out_valid & ~out_ready stalls the output register and deasserts all req_ready.
//
// Ports: clk, rst (async, active-high); req_valid/req_data/req_ready per requester;
//        out_valid/out_ready/out_data/out_sel registered output stage.
// Optional: define MUX_ARB_LOCK_EN to add req_lock[3:0], letting a granted
//           requester hold the arbiter across consecutive beats.
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output req_idx_t                      out_sel
);

    arb_state_t       state;
    req_idx_t         ptr;
    req_idx_t         ptr_nxt;
    req_idx_t         gidx;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] mux_out;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;
    logic             lock_nxt;
`endif

    rr_pick4 u_pick (
        .req  (req_valid),
        .ptr  (ptr),
        .gidx (gidx),
        .any  (any)
    );

    mux_4x1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in0 (req_data[0]),
        .in1 (req_data[1]),
        .in2 (req_data[2]),
        .in3 (req_data[3]),
        .sel (gidx),
        .out (mux_out)
    );

    assign out_valid = (state == FULL);

    // rst gates load so no requester sees ready while reset is held.
    assign load = (~out_valid | out_ready) & any & ~rst;

    always_comb begin
        req_ready       = '0;
        req_ready[gidx] = load;
    end

    // While locked, ptr already sits on the owner, so the plain rotating
    // search gives it first priority whenever it is still valid.
    always_comb begin
        ptr_nxt = ptr;
`ifdef MUX_ARB_LOCK_EN
        lock_nxt = lock;
`endif
        if (load) begin
`ifdef MUX_ARB_LOCK_EN
            if (req_lock[gidx]) begin
                lock_nxt = 1'b1;
                ptr_nxt  = gidx;
            end else begin
                lock_nxt = 1'b0;
                ptr_nxt  = idx_inc(gidx);
            end
`else
            ptr_nxt = idx_inc(gidx);
`endif
        end
`ifdef MUX_ARB_LOCK_EN
        else if (lock && !req_valid[ptr]) begin
            // Owner went away without releasing: release on its behalf.
            lock_nxt = 1'b0;
            ptr_nxt  = idx_inc(ptr);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
`ifdef MUX_ARB_LOCK_EN
            lock     <= 1'b0;
`endif
        end else begin
            ptr <= ptr_nxt;
`ifdef MUX_ARB_LOCK_EN
            lock <= lock_nxt;
`endif
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= FULL;
                        out_data <= mux_out;
                        out_sel  <= gidx;
                    end
                end
                FULL: begin
                    if (load) begin
                        out_data <= mux_out;
                        out_sel  <= gidx;
                    end else if (out_ready) begin
                        // Drained with nothing to refill: data/sel keep last word.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
Name: mux_4x1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 datapath mux between four requesters.
- Each requester offers a WIDTH-bit word with a valid/ready handshake. The arbiter picks one requester per cycle, drives the existing mux_4x1 select, and captures the selected word into a registered output stage with its own valid/ready handshake.
- Sits in front of shared MIPS datapath resources (e.g. writeback or memory-port sharing).

Parameters:
- WIDTH, 32, data width of each requester word and of the output word.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  4  per-requester valid; bit i = requester i.
- req_data  input  4xWIDTH  packed array of requester words; [i] belongs to requester i.
- req_ready  output  4  per-requester ready; combinational, one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  2  index of the requester whose word is in out_data; registered.

Interface rule: one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Reset: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0, state IDLE. Asserting rst mid-transfer drops the held word immediately. No req_ready is asserted while rst=1.
- load = (~out_valid | out_ready) & |req_valid.
- Grant selection:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted req_valid bit wins (gidx).
  - gidx drives the mux_4x1 sel.
  - req_ready[gidx] = load; all other req_ready bits are 0.
- On a load cycle edge:
  - out_data <= mux output.
  - out_sel <= gidx.
  - out_valid <= 1.
  - ptr <= gidx+1 (2-bit wrap: 3 -> 0).
- If out_valid & out_ready & no req_valid: out_valid <= 0. out_data and out_sel hold their values.
- If out_valid & ~out_ready: the output is stalled. out_data and out_sel are stable, all req_ready=0, ptr holds.
- Latency: one cycle from the request handshake to out_valid. Back-to-back transfers give full throughput (1 word/cycle) while out_ready=1.
- FSM:
  - IDLE (out_valid=0): goes to FULL on load.
  - FULL (out_valid=1): stays in FULL on load, or on stall (~out_ready). Goes to IDLE when out_ready & no req_valid.
- Fairness: with all four requesters valid continuously, grants rotate 0,1,2,3,0... No requester waits more than 3 grants.
- Requesters must hold req_valid and req_data until they see req_ready. The arbiter does not check this.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock (4 bits).
  - When requester i is granted with req_lock[i]=1, a lock flag is set. ptr is not advanced; it stays at i.
  - While the lock flag is set and req_valid[i]=1, i wins unconditionally.
  - The lock flag clears on a granted beat with req_lock[i]=0. ptr then advances to i+1.
  - The lock flag also clears if req_valid[i] drops. ptr then advances to i+1.
  - Reset clears the lock flag.
- Undefined: no req_lock port; pure round-robin as above.

Decomposition:
- Package mux_arb_pkg:
  - NUM_REQ=4.
  - typedef logic [1:0] req_idx_t.
  - typedef enum {IDLE, FULL} arb_state_t.
- Sub-module rr_pick4 (combinational): inputs req[3:0] and ptr; outputs gidx and any. This is the natural split.
- mux_4x1 is instantiated unchanged as the data path.

Test Plan:
- Reset: rst=1 with all req_valid=1 -> out_valid=0, out_data=0, req_ready=0. Release rst, out_ready=1 -> first grant is idx0.
- Rotation: req_valid=4'b1111, data i = 32'hA0+i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data matches.
- Skip/wrap:
  - Start with ptr=2 (after grants to 0 and 1), then req_valid=4'b0001 -> grant 0; ptr becomes 1.
  - Next, req_valid=4'b1000 -> grant 3; ptr wraps to 0.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles, req_valid=4'b0110 -> out_data and out_sel stable, req_ready=0. On out_ready=1 the next grant goes to the requester after the held out_sel.
- Reset mid-stall: word 32'hDEADBEEF held with out_ready=0, pulse rst asynchronously -> out_valid=0 immediately; ptr=0 afterwards.
- MUX_ARB_LOCK_EN:
  - req_valid=4'b1111 with req_lock[1] high for 3 beats -> out_sel 1,1,1.
  - Requester 1 then drops lock -> grants continue 1,2,3,...
